// File: rtl/ui_bus_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the UI device controller.
// The slave view is the arbiter; the master view is the requester/device side.
interface ui_bus_arbiter_if #(
  parameter int DBITS = 32
);
  logic [1:0]       req;
  logic             wrtEn0;
  logic             wrtEn1;
  logic [1:0]       uiDevice0;
  logic [1:0]       uiDevice1;
  logic [DBITS-1:0] in0;
  logic [DBITS-1:0] in1;
  logic [1:0]       lock;
  logic [1:0]       ack;
  logic [DBITS-1:0] rdata;
  logic             busy;
  logic             dev_wrtEn;
  logic [1:0]       dev_uiDevice;
  logic [DBITS-1:0] dev_in;
  logic [DBITS-1:0] dev_out;

  modport slave (
    input  req, wrtEn0, wrtEn1, uiDevice0, uiDevice1, in0, in1, lock, dev_out,
    output ack, rdata, busy, dev_wrtEn, dev_uiDevice, dev_in
  );

  modport master (
    output req, wrtEn0, wrtEn1, uiDevice0, uiDevice1, in0, in1, lock, dev_out,
    input  ack, rdata, busy, dev_wrtEn, dev_uiDevice, dev_in
  );
endinterface

// File: rtl/ui_bus_arbiter.sv
// Round-robin two-port arbiter in front of the UI device controller, one access in flight.
// Define UI_ARB_LOCK_EN to let a port keep the grant for up to 4 locked accesses.
module ui_bus_arbiter #(
  parameter int DBITS = 32
) (
  input logic            clk,
  input logic            reset,
  ui_bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic             winner_reg, winner_next;
  logic             last_served_reg, last_served_next;
  logic             dev_wrten_reg, dev_wrten_next;
  logic [1:0]       cmd_dev_reg, cmd_dev_next;
  logic [DBITS-1:0] cmd_in_reg, cmd_in_next;
  logic [DBITS-1:0] rdata_reg, rdata_next;
  logic             grant;
  wire  [1:0]       ack_vec;

`ifdef UI_ARB_LOCK_EN
  logic             lock_hold_reg, lock_hold_next;
  logic [1:0]       lock_cnt_reg, lock_cnt_next;
`else
  logic             lock_unused;
  assign lock_unused = ^bus.lock;
`endif

  always_comb begin
    case (bus.req)
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_served_reg;
      default: grant = 1'b0;
    endcase
`ifdef UI_ARB_LOCK_EN
    // A held lock overrides round-robin as long as the locking port is still asking.
    if (lock_hold_reg && bus.req[winner_reg]) begin
      grant = winner_reg;
    end
`endif
  end

  always_comb begin
    state_next       = state_reg;
    winner_next      = winner_reg;
    last_served_next = last_served_reg;
    dev_wrten_next   = dev_wrten_reg;
    cmd_dev_next     = cmd_dev_reg;
    cmd_in_next      = cmd_in_reg;
    rdata_next       = rdata_reg;
`ifdef UI_ARB_LOCK_EN
    lock_hold_next   = lock_hold_reg;
    lock_cnt_next    = lock_cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (bus.req != 2'b00) begin
          winner_next    = grant;
          dev_wrten_next = grant ? bus.wrtEn1    : bus.wrtEn0;
          cmd_dev_next   = grant ? bus.uiDevice1 : bus.uiDevice0;
          cmd_in_next    = grant ? bus.in1       : bus.in0;
`ifdef UI_ARB_LOCK_EN
          if (!(lock_hold_reg && (grant == winner_reg))) begin
            lock_cnt_next = 2'd0;
          end
`endif
          state_next     = ACCESS;
        end
      end
      ACCESS: begin
        dev_wrten_next = 1'b0;
        rdata_next     = bus.dev_out;
        state_next     = RESP;
`ifdef UI_ARB_LOCK_EN
        // The fourth consecutive locked grant releases the lock unconditionally.
        if (bus.lock[winner_reg] && (lock_cnt_reg != 2'd3)) begin
          lock_hold_next = 1'b1;
          lock_cnt_next  = lock_cnt_reg + 2'd1;
        end else begin
          last_served_next = winner_reg;
          lock_hold_next   = 1'b0;
          lock_cnt_next    = 2'd0;
        end
`else
        last_served_next = winner_reg;
`endif
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      winner_reg      <= 1'b0;
      last_served_reg <= 1'b1;
      dev_wrten_reg   <= 1'b0;
      cmd_dev_reg     <= 2'b00;
      cmd_in_reg      <= '0;
      rdata_reg       <= '0;
`ifdef UI_ARB_LOCK_EN
      lock_hold_reg   <= 1'b0;
      lock_cnt_reg    <= 2'd0;
`endif
    end else begin
      state_reg       <= state_next;
      winner_reg      <= winner_next;
      last_served_reg <= last_served_next;
      dev_wrten_reg   <= dev_wrten_next;
      cmd_dev_reg     <= cmd_dev_next;
      cmd_in_reg      <= cmd_in_next;
      rdata_reg       <= rdata_next;
`ifdef UI_ARB_LOCK_EN
      lock_hold_reg   <= lock_hold_next;
      lock_cnt_reg    <= lock_cnt_next;
`endif
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ack
      assign ack_vec[gi] = (state_reg == RESP) && (winner_reg == 1'(gi));
    end
  endgenerate

  assign bus.ack          = ack_vec;
  assign bus.rdata        = rdata_reg;
  assign bus.busy         = (state_reg != IDLE);
  assign bus.dev_wrtEn    = dev_wrten_reg;
  assign bus.dev_uiDevice = cmd_dev_reg;
  assign bus.dev_in       = cmd_in_reg;
endmodule

// File: tb/tb_ui_bus_arbiter.sv
// Self-checking bench for ui_bus_arbiter with a small UI device model and an ack scoreboard.
// Build with UI_ARB_LOCK_EN defined to exercise the lock ordering.
module tb_ui_bus_arbiter;
  localparam int DBITS = 32;
  localparam logic [1:0] KEY  = 2'd0;
  localparam logic [1:0] SW   = 2'd1;
  localparam logic [1:0] LEDR = 2'd2;
  localparam logic [1:0] HEX  = 2'd3;
  localparam logic [31:0] KEY_VAL = 32'h0000_0005;
  localparam logic [31:0] SW_VAL  = 32'h0000_03C1;

  typedef struct packed {
    logic [1:0]  ack;
    logic [31:0] rdata;
    logic        chk;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ledr_q = 32'h0;
  logic [31:0] hex_q  = 32'h0;
  int          wrt_cycles = 0;
  int          vectors = 0;
  int          miscompares = 0;
  exp_t        sb_q[$];

  always #5 clk = ~clk;

  ui_bus_arbiter_if #(.DBITS(DBITS)) bus ();

  ui_bus_arbiter #(.DBITS(DBITS)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // UI controller model: writes commit on the falling edge, reads are combinational.
  always @(negedge clk) begin
    if (bus.dev_wrtEn === 1'b1) begin
      wrt_cycles <= wrt_cycles + 1;
      if (bus.dev_uiDevice == LEDR) ledr_q <= bus.dev_in;
      else if (bus.dev_uiDevice == HEX) hex_q <= bus.dev_in;
    end
  end

  always_comb begin
    case (bus.dev_uiDevice)
      KEY:     bus.dev_out = KEY_VAL;
      SW:      bus.dev_out = SW_VAL;
      LEDR:    bus.dev_out = ledr_q;
      default: bus.dev_out = hex_q;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req = 2'b00; bus.lock = 2'b00;
    bus.wrtEn0 = 1'b0; bus.wrtEn1 = 1'b0;
    bus.uiDevice0 = 2'b00; bus.uiDevice1 = 2'b00;
    bus.in0 = '0; bus.in1 = '0;
  endtask

  task automatic drive_port(input bit p, input bit wr, input logic [1:0] dev,
                            input logic [31:0] data, input bit lk);
    if (!p) begin
      bus.wrtEn0 = wr; bus.uiDevice0 = dev; bus.in0 = data; bus.lock[0] = lk; bus.req[0] = 1'b1;
    end else begin
      bus.wrtEn1 = wr; bus.uiDevice1 = dev; bus.in1 = data; bus.lock[1] = lk; bus.req[1] = 1'b1;
    end
  endtask

  task automatic drop_port(input bit p);
    bus.req[p]  = 1'b0;
    bus.lock[p] = 1'b0;
  endtask

  // Returns the number of edges until ack is seen, or -1 when the budget runs out.
  task automatic wait_ack(input int limit, output int cyc);
    cyc = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (bus.ack !== 2'b00) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    idle_inputs();
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    repeat (3) tick();
    vectors++;
    if ({bus.ack, bus.busy, bus.dev_wrtEn, bus.dev_uiDevice} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: ack=%b busy=%b wrtEn=%b dev=%b required all 0",
               bus.ack, bus.busy, bus.dev_wrtEn, bus.dev_uiDevice);
    end
    vectors++;
    if ({bus.dev_in, bus.rdata} !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_data: dev_in=%h rdata=%h required 0", bus.dev_in, bus.rdata);
    end
    reset = 1'b1;
    tick();
    $display("txn reset checked");
  endtask

  task automatic test_write_ledr();
    int   lat;
    int   w0;
    exp_t e;
    w0 = wrt_cycles;
    drive_port(1'b0, 1'b1, LEDR, 32'h2A5, 1'b0);
    sb_q.push_back('{ack: 2'b01, rdata: 32'h0, chk: 1'b0});
    tick();
    vectors++;
    if (bus.dev_wrtEn !== 1'b1 || bus.busy !== 1'b1 || bus.dev_uiDevice !== LEDR || bus.dev_in !== 32'h2A5) begin
      miscompares++;
      $display("FAIL write_access: wrtEn=%b busy=%b dev=%b din=%h required 1 1 10 000002a5",
               bus.dev_wrtEn, bus.busy, bus.dev_uiDevice, bus.dev_in);
    end
    wait_ack(8, lat);
    vectors++;
    if (lat !== 1) begin
      miscompares++;
      $display("FAIL write_latency: edges to ack=%0d required 2", (lat < 0) ? lat : lat + 1);
    end
    drop_port(1'b0);
    e = sb_q.pop_front();
    vectors++;
    if (bus.ack !== e.ack || bus.dev_wrtEn !== 1'b0) begin
      miscompares++;
      $display("FAIL write_ack: ack=%b wrtEn=%b required ack=%b wrtEn=0", bus.ack, bus.dev_wrtEn, e.ack);
    end else $display("txn write LEDR port0 ack=%b", bus.ack);
    tick();
    vectors++;
    if (bus.ack !== 2'b00 || bus.busy !== 1'b0 || (wrt_cycles - w0) !== 1 || ledr_q !== 32'h2A5) begin
      miscompares++;
      $display("FAIL write_after: ack=%b busy=%b wrt_cycles=%0d ledr=%h required 00 0 1 000002a5",
               bus.ack, bus.busy, wrt_cycles - w0, ledr_q);
    end
    drive_port(1'b1, 1'b0, LEDR, 32'h0, 1'b0);
    sb_q.push_back('{ack: 2'b10, rdata: 32'h2A5, chk: 1'b1});
    wait_ack(8, lat);
    drop_port(1'b1);
    e = sb_q.pop_front();
    vectors++;
    if (lat !== 2 || bus.ack !== e.ack || bus.rdata !== e.rdata) begin
      miscompares++;
      $display("FAIL read_ledr: lat=%0d ack=%b rdata=%h required lat=2 ack=%b rdata=%h",
               lat, bus.ack, bus.rdata, e.ack, e.rdata);
    end else $display("txn read LEDR port1 ack=%b rdata=%h", bus.ack, bus.rdata);
    tick();
  endtask

  task automatic test_read_sw();
    int   lat;
    int   w0;
    exp_t e;
    w0 = wrt_cycles;
    drive_port(1'b1, 1'b0, SW, 32'h0, 1'b0);
    sb_q.push_back('{ack: 2'b10, rdata: SW_VAL, chk: 1'b1});
    wait_ack(8, lat);
    drop_port(1'b1);
    e = sb_q.pop_front();
    vectors++;
    if (lat !== 2 || bus.ack !== e.ack || bus.rdata !== e.rdata) begin
      miscompares++;
      $display("FAIL read_sw: lat=%0d ack=%b rdata=%h required lat=2 ack=%b rdata=%h",
               lat, bus.ack, bus.rdata, e.ack, e.rdata);
    end else $display("txn read SW port1 ack=%b rdata=%h", bus.ack, bus.rdata);
    tick();
    vectors++;
    if (wrt_cycles !== w0) begin
      miscompares++;
      $display("FAIL read_sw_wrten: write cycles=%0d required 0", wrt_cycles - w0);
    end
  endtask

  task automatic test_back_to_back();
    int   lat;
    exp_t e;
    pulse_reset();
    drive_port(1'b0, 1'b0, SW, 32'h0, 1'b0);
    drive_port(1'b1, 1'b0, LEDR, 32'h0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) sb_q.push_back('{ack: 2'b01, rdata: SW_VAL, chk: 1'b1});
      else            sb_q.push_back('{ack: 2'b10, rdata: ledr_q, chk: 1'b1});
    end
    for (int i = 0; i < 6; i++) begin
      wait_ack(10, lat);
      if (i == 5) begin
        drop_port(1'b0);
        drop_port(1'b1);
      end
      e = sb_q.pop_front();
      vectors++;
      if (lat !== ((i == 0) ? 2 : 3) || bus.ack !== e.ack || bus.rdata !== e.rdata) begin
        miscompares++;
        $display("FAIL b2b_%0d: gap=%0d ack=%b rdata=%h required gap=%0d ack=%b rdata=%h",
                 i, lat, bus.ack, bus.rdata, (i == 0) ? 2 : 3, e.ack, e.rdata);
      end else $display("txn b2b %0d ack=%b rdata=%h gap=%0d", i, bus.ack, bus.rdata, lat);
    end
    tick();
  endtask

  task automatic test_busy_sample();
    exp_t e;
    drive_port(1'b0, 1'b1, HEX, 32'hBEEF, 1'b0);
    sb_q.push_back('{ack: 2'b01, rdata: 32'h0, chk: 1'b0});
    tick();
    drive_port(1'b1, 1'b0, HEX, 32'h0, 1'b0);
    sb_q.push_back('{ack: 2'b10, rdata: 32'hBEEF, chk: 1'b1});
    tick();
    drop_port(1'b0);
    e = sb_q.pop_front();
    vectors++;
    if (bus.ack !== e.ack) begin
      miscompares++;
      $display("FAIL hex_write_ack: ack=%b required %b", bus.ack, e.ack);
    end else $display("txn write HEX port0 ack=%b", bus.ack);
    tick();
    vectors++;
    if (bus.busy !== 1'b0 || bus.ack !== 2'b00) begin
      miscompares++;
      $display("FAIL resp_not_sampled: busy=%b ack=%b required busy=0 ack=00", bus.busy, bus.ack);
    end
    tick();
    vectors++;
    if (bus.busy !== 1'b1 || bus.dev_wrtEn !== 1'b0 || bus.dev_uiDevice !== HEX) begin
      miscompares++;
      $display("FAIL port1_access: busy=%b wrtEn=%b dev=%b required 1 0 11",
               bus.busy, bus.dev_wrtEn, bus.dev_uiDevice);
    end
    tick();
    drop_port(1'b1);
    e = sb_q.pop_front();
    vectors++;
    if (bus.ack !== e.ack || bus.rdata !== e.rdata) begin
      miscompares++;
      $display("FAIL hex_read: ack=%b rdata=%h required ack=%b rdata=%h", bus.ack, bus.rdata, e.ack, e.rdata);
    end else $display("txn read HEX port1 ack=%b rdata=%h", bus.ack, bus.rdata);
    tick();
  endtask

  task automatic test_reset_abort();
    int          lat;
    logic [31:0] l0;
    exp_t        e;
    l0 = ledr_q;
    drive_port(1'b0, 1'b1, LEDR, 32'h123, 1'b0);
    tick();
    vectors++;
    if (bus.dev_wrtEn !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_pre: wrtEn=%b required 1", bus.dev_wrtEn);
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (bus.dev_wrtEn !== 1'b0 || bus.busy !== 1'b0 || bus.ack !== 2'b00) begin
      miscompares++;
      $display("FAIL abort_async: wrtEn=%b busy=%b ack=%b required 0 0 00", bus.dev_wrtEn, bus.busy, bus.ack);
    end
    drop_port(1'b0);
    tick();
    tick();
    vectors++;
    if (bus.ack !== 2'b00 || ledr_q !== l0) begin
      miscompares++;
      $display("FAIL abort_noack: ack=%b ledr=%h required ack=00 ledr=%h", bus.ack, ledr_q, l0);
    end
    reset = 1'b1;
    tick();
    drive_port(1'b0, 1'b0, KEY, 32'h0, 1'b0);
    drive_port(1'b1, 1'b0, SW, 32'h0, 1'b0);
    sb_q.push_back('{ack: 2'b01, rdata: KEY_VAL, chk: 1'b1});
    wait_ack(8, lat);
    drop_port(1'b0);
    drop_port(1'b1);
    e = sb_q.pop_front();
    vectors++;
    if (lat !== 2 || bus.ack !== e.ack || bus.rdata !== e.rdata) begin
      miscompares++;
      $display("FAIL abort_tie: lat=%0d ack=%b rdata=%h required lat=2 ack=%b rdata=%h",
               lat, bus.ack, bus.rdata, e.ack, e.rdata);
    end else $display("txn post-abort tie ack=%b rdata=%h", bus.ack, bus.rdata);
    tick();
  endtask

  task automatic test_lock();
    int   lat;
    exp_t e;
    logic [1:0] order [5];
`ifdef UI_ARB_LOCK_EN
    order = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
`else
    order = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
`endif
    pulse_reset();
    drive_port(1'b0, 1'b0, KEY, 32'h0, 1'b1);
    drive_port(1'b1, 1'b0, SW, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      sb_q.push_back('{ack: order[i], rdata: (order[i] == 2'b01) ? KEY_VAL : SW_VAL, chk: 1'b1});
    end
    for (int i = 0; i < 5; i++) begin
      wait_ack(10, lat);
      if (i == 4) begin
        drop_port(1'b0);
        drop_port(1'b1);
      end
      e = sb_q.pop_front();
      vectors++;
      if (lat < 0 || bus.ack !== e.ack || bus.rdata !== e.rdata) begin
        miscompares++;
        $display("FAIL lock_%0d: lat=%0d ack=%b rdata=%h required ack=%b rdata=%h",
                 i, lat, bus.ack, bus.rdata, e.ack, e.rdata);
      end else $display("txn lock %0d ack=%b rdata=%h", i, bus.ack, bus.rdata);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_ledr();
    test_read_sw();
    test_back_to_back();
    test_busy_sample();
    test_reset_abort();
    test_lock();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ui_bus_arbiter.md
# ui_bus_arbiter

Two-port arbiter that shares the single UI device port (keys, switches, red LEDs, hex display) between the CPU datapath (port 0) and an auxiliary master such as a debug/monitor engine (port 1). It sits between the requesters and the UI controller. It accepts one request per port, grants round-robin, drives one device access, captures read data and returns a one-cycle acknowledge. Only one access is ever in flight on the device port.

## Interface
- DBITS, 32, data width of write data, read data and the device port

- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  2  per-port request; bit i = port i
- wrtEn0 / wrtEn1  in  1  port command: 1 = write, 0 = read
- uiDevice0 / uiDevice1  in  2  target device code (KEY, SW, LEDR, HEX encodings)
- in0 / in1  in  DBITS  port write data
- lock  in  2  per-port lock request; used only with UI_ARB_LOCK_EN, otherwise ignored
- ack  out  2  one-cycle completion pulse to the served port
- rdata  out  DBITS  read data of the completed access; valid while ack != 0
- busy  out  1  high in ACCESS and RESP
- dev_wrtEn  out  1  write enable to UI controller
- dev_uiDevice  out  2  device select to UI controller
- dev_in  out  DBITS  write data to UI controller
- dev_out  in  DBITS  read data from UI controller (combinational on dev_uiDevice)

## Operation
- States: IDLE, ACCESS, RESP. Reset state IDLE.
- IDLE: if req == 0, stay. Otherwise pick a winner. A single request wins. With both requesting, the port not equal to last_served wins. Latch the winner's wrtEn, uiDevice and in into the command register, record the winner, then go to ACCESS.
- ACCESS (exactly 1 cycle): drive dev_uiDevice/dev_in from the command register and dev_wrtEn = latched wrtEn. On the closing edge, capture dev_out into rdata (also for writes), set last_served = winner, go to RESP.
- RESP (exactly 1 cycle): ack[winner] = 1, rdata held. Requests are not sampled. Go to IDLE.
- Requester contract: hold req and command stable from assertion until ack. A req still high in the cycle after ack is a new request.
- Command inputs are sampled only on the IDLE→ACCESS edge. Changes while busy are ignored.
- Dropping req before ack is a protocol violation. An access already latched still completes and acks.
- dev_wrtEn is 0 in IDLE and RESP. dev_uiDevice/dev_in hold the last latched command outside ACCESS.
- Reset values: state IDLE, ack 0, rdata 0, busy 0, dev_wrtEn 0, dev_uiDevice 0, dev_in 0, last_served 1 (port 0 wins the first tie).
- Reset asserted mid-transaction aborts immediately to the reset values. No ack is produced. dev_wrtEn drops asynchronously.

## Timing
- Request seen at rising edge E (state IDLE) → ACCESS in cycle E..E+1 → ack high in cycle E+1..E+2.
- Latency: 2 cycles from sampling edge to ack. Throughput: one access per 3 cycles.
- The UI controller commits writes on the falling edge inside ACCESS. dev_wrtEn/dev_uiDevice/dev_in are registered and stable for the full ACCESS cycle.
- Read data reflects device state at the end of ACCESS.
- Fairness: with both ports continuously requesting, grants strictly alternate 0,1,0,1… Worst-case wait is 6 cycles.

## Configuration
- UI_ARB_LOCK_EN defined: when an access completes with lock[winner] = 1 sampled on the ACCESS→RESP edge, last_served is not updated. If that port is requesting in the next IDLE, it wins even against the other port. This allows atomic read-modify-write of LEDR/HEX. A lock holds for at most 4 consecutive grants; the 4th grant updates last_served regardless.
- Not defined: the lock input is unused and arbitration is pure round-robin as above.

## Test plan
- Reset, then port 0 write LEDR with in0 = 0x2A5 → dev_wrtEn high exactly one cycle; ack = 01 two cycles after sampling; a later port 1 read of LEDR returns rdata = 0x2A5.
- Port 1 read of SW with dev_out modelled as 0x3C1 → ack = 10 with rdata = 0x3C1; dev_wrtEn never asserted.
- Both ports request simultaneously after reset, continuously, for 6 transactions → ack order 01,10,01,10,01,10, each 3 cycles apart.
- Port 0 write HEX 0xBEEF; port 1 asserts req during ACCESS → port 1 is not sampled until after RESP, and its access starts in the IDLE following the RESP cycle.
- Reset pulled low during ACCESS of a write → dev_wrtEn drops immediately, no ack, busy 0; after release the arbiter is idle and the first tie goes to port 0.
- With UI_ARB_LOCK_EN defined: port 0 requests continuously with lock = 1 while port 1 also requests → port 0 receives 4 grants, then port 1 is granted. Without the macro, the same stimulus alternates 0,1.
